// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: picks which warp owns the shared core datapath.
// Rotates away from memory-stalled warps, enforces a time-slice quantum at
// instruction boundaries, retires finished warps and flags kernel completion.
module warp_scheduler #(
  parameter int unsigned NUM_WARPS      = 2,
  parameter int unsigned QUANTUM        = 8,
  parameter int unsigned SWITCH_PENALTY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_WARPS-1:0]         warp_enable,
  input  logic [NUM_WARPS-1:0]         warp_done,
  input  logic [NUM_WARPS-1:0]         warp_stalled,
  input  logic                         boundary,
  output logic [$clog2(NUM_WARPS)-1:0] warp_select,
  output logic                         warp_valid,
  output logic                         switch_pulse,
  output logic                         done
);

  localparam int unsigned SW  = $clog2(NUM_WARPS);
  localparam int unsigned SW1 = SW + 1;
  localparam int unsigned QW  = (QUANTUM < 1) ? 1 : $clog2(QUANTUM + 1);
  localparam logic [QW-1:0] QMAX  = QW'(QUANTUM);
  localparam logic [QW-1:0] QLIM  = (QUANTUM == 0) ? '0 : QW'(QUANTUM - 1);
  localparam logic          QEN   = (QUANTUM != 0);
  localparam logic [3:0]    PLOAD = 4'(SWITCH_PENALTY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SWITCH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          valid_q, valid_d;
  logic          pulse_q, pulse_d;
  logic          done_q, done_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [3:0]    pcnt_q, pcnt_d;

  logic [NUM_WARPS-1:0] live;
  logic [NUM_WARPS-1:0] runnable;
  logic [SW:0]          pick_run;
  logic [SW:0]          pick_live;
  logic [SW-1:0]        first_en;
  logic                 cur_done;
  logic                 cur_stalled;

  // First set bit of mask searching cur+1, cur+2, ... (mod NUM_WARPS), never cur.
  // Result is {found, index}.
  function automatic logic [SW:0] rr_pick(input logic [NUM_WARPS-1:0] mask,
                                          input logic [SW-1:0]        cur);
    logic [SW:0] pos;
    logic [SW:0] res;
    res = '0;
    for (int unsigned k = 1; k < NUM_WARPS; k++) begin
      pos = {1'b0, cur} + SW1'(k);
      if (pos >= SW1'(NUM_WARPS)) begin
        pos = pos - SW1'(NUM_WARPS);
      end
      if (!res[SW] && mask[pos[SW-1:0]]) begin
        res = {1'b1, pos[SW-1:0]};
      end
    end
    return res;
  endfunction

  assign live        = warp_enable & ~warp_done;
  assign runnable    = live & ~warp_stalled;
  assign pick_run    = rr_pick(runnable, sel_q);
  assign pick_live   = rr_pick(live, sel_q);
  assign cur_done    = warp_done[sel_q];
  assign cur_stalled = warp_stalled[sel_q];

  // Lowest-index enabled warp, used as the launch target.
  always_comb begin
    logic [SW-1:0] idx;
    first_en = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      idx = SW'(NUM_WARPS - 1 - i);
      if (warp_enable[idx]) begin
        first_en = idx;
      end
    end
  end

  // Next-state and next-output computation for the scheduling FSM.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    pulse_d = 1'b0;
    done_d  = done_q;
    qcnt_d  = qcnt_q;
    pcnt_d  = pcnt_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        valid_d = 1'b0;
        if (start) begin
          qcnt_d = '0;
          if (warp_enable == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            sel_d   = first_en;
            valid_d = 1'b1;
            done_d  = 1'b0;
          end
        end
      end

      S_RUN: begin
        valid_d = 1'b1;
        if (qcnt_q != QMAX) begin
          qcnt_d = qcnt_q + QW'(1);
        end
        if (boundary || cur_done) begin
          if (live == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end else if (cur_done) begin
            // A finished warp must leave even if every other live warp is stalled.
            if (pick_run[SW]) begin
              state_d = S_SWITCH;
              sel_d   = pick_run[SW-1:0];
              pulse_d = 1'b1;
              valid_d = 1'b0;
              pcnt_d  = PLOAD;
              qcnt_d  = '0;
            end else if (pick_live[SW]) begin
              state_d = S_SWITCH;
              sel_d   = pick_live[SW-1:0];
              pulse_d = 1'b1;
              valid_d = 1'b0;
              pcnt_d  = PLOAD;
              qcnt_d  = '0;
            end
          end else if (cur_stalled || (QEN && (qcnt_q >= QLIM))) begin
            if (pick_run[SW]) begin
              state_d = S_SWITCH;
              sel_d   = pick_run[SW-1:0];
              pulse_d = 1'b1;
              valid_d = 1'b0;
              pcnt_d  = PLOAD;
              qcnt_d  = '0;
            end else begin
              // Nobody else can run: keep the current warp but restart its slice.
              qcnt_d = '0;
            end
          end
        end
      end

      S_SWITCH: begin
        valid_d = 1'b0;
        qcnt_d  = '0;
        if (pcnt_q == '0) begin
          state_d = S_RUN;
          valid_d = 1'b1;
        end else begin
          pcnt_d = pcnt_q - 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      qcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      qcnt_q  <= qcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign warp_select  = sel_q;
  assign warp_valid   = valid_q;
  assign switch_pulse = pulse_q;
  assign done         = done_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: a QUANTUM=8 instance and a QUANTUM=0
// instance share one stimulus stream; their outputs are checked separately.
module tb_warp_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       boundary;
  logic [1:0] warp_enable;
  logic [1:0] warp_done;
  logic [1:0] warp_stalled;

  logic [0:0] sel8, sel0;
  logic       vld8, vld0, pls8, pls0, dn8, dn0;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    logic       rst;
    logic       go;
    logic [1:0] en;
    logic [1:0] dn;
    logic [1:0] st;
    logic       bnd;
    logic       sel;
    logic       vld;
    logic       pls;
    logic       dne;
  } vec_t;

  vec_t vecs[19];

  always #5 clk = ~clk;

  warp_scheduler #(.NUM_WARPS(2), .QUANTUM(8), .SWITCH_PENALTY(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .warp_enable  (warp_enable),
    .warp_done    (warp_done),
    .warp_stalled (warp_stalled),
    .boundary     (boundary),
    .warp_select  (sel8),
    .warp_valid   (vld8),
    .switch_pulse (pls8),
    .done         (dn8)
  );

  warp_scheduler #(.NUM_WARPS(2), .QUANTUM(0), .SWITCH_PENALTY(1)) dut_q0 (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .warp_enable  (warp_enable),
    .warp_done    (warp_done),
    .warp_stalled (warp_stalled),
    .boundary     (boundary),
    .warp_select  (sel0),
    .warp_valid   (vld0),
    .switch_pulse (pls0),
    .done         (dn0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic go, input logic [1:0] en,
                       input logic [1:0] dn, input logic [1:0] st, input logic bnd);
    reset        = rst;
    start        = go;
    warp_enable  = en;
    warp_done    = dn;
    warp_stalled = st;
    boundary     = bnd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic s, input logic v, input logic p, input logic d);
    check({tag, " q8 sel"},   32'(sel8), 32'(s));
    check({tag, " q8 valid"}, 32'(vld8), 32'(v));
    check({tag, " q8 pulse"}, 32'(pls8), 32'(p));
    check({tag, " q8 done"},  32'(dn8),  32'(d));
  endtask

  task automatic chk0(input string tag, input logic s, input logic v, input logic p, input logic d);
    check({tag, " q0 sel"},   32'(sel0), 32'(s));
    check({tag, " q0 valid"}, 32'(vld0), 32'(v));
    check({tag, " q0 pulse"}, 32'(pls0), 32'(p));
    check({tag, " q0 done"},  32'(dn0),  32'(d));
  endtask

  initial begin
    // Each row: inputs applied for one cycle, outputs expected after that edge.
    //            rst go  en     dn     st     bnd  sel vld pls done
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // launch -> warp 0
    vecs[3]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // w0 stalled at boundary
    vecs[5]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // penalty over
    vecs[6]  = '{1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // start in RUN ignored
    vecs[7]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // both stalled: stay
    vecs[8]  = '{1'b0, 1'b0, 2'b11, 2'b10, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // w1 done + boundary: done rule wins
    vecs[9]  = '{1'b0, 1'b0, 2'b11, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // stall drop: no preempt
    vecs[11] = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // w0 done -> DONE
    vecs[12] = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // relaunch, en=10
    vecs[14] = '{1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // en=00 -> DONE
    vecs[17] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // start from DONE

    drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    for (int unsigned i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].go, vecs[i].en, vecs[i].dn, vecs[i].st, vecs[i].bnd);
      step();
      chk8($sformatf("row%0d", i), vecs[i].sel, vecs[i].vld, vecs[i].pls, vecs[i].dne);
      chk0($sformatf("row%0d", i), vecs[i].sel, vecs[i].vld, vecs[i].pls, vecs[i].dne);
    end

    // Reset held for three cycles while warp 1 is running.
    drive(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0); step();
    drive(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0); step();
    chk8("rst launch", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'b11, 2'b00, 2'b01, 1'b1); step();
    chk8("rst sw", 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0); step();
    chk8("rst run1", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int unsigned r = 0; r < 3; r++) begin
      drive(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0); step();
      chk8($sformatf("rst hold%0d", r), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0); step();
    chk8("rst idle", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0); step();
    chk8("rst relaunch", 1'b0, 1'b1, 1'b0, 1'b0);

    // Quantum rotation: boundary on the 4th and 8th RUN cycle of each slice.
    // With QUANTUM=8 each 9-cycle segment is 8 RUN cycles plus one bubble;
    // with QUANTUM=0 warp 0 is never preempted.
    drive(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0); step();
    drive(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0); step();
    for (int unsigned c = 0; c < 36; c++) begin
      int unsigned seg;
      int unsigned m;
      logic        exp_sel;
      seg = c / 9;
      m   = c % 9;
      if (m < 8) begin
        exp_sel = seg[0];
        chk8($sformatf("quant c%0d", c), exp_sel, 1'b1, 1'b0, 1'b0);
      end else begin
        exp_sel = ~seg[0];
        chk8($sformatf("quant c%0d", c), exp_sel, 1'b0, 1'b1, 1'b0);
      end
      chk0($sformatf("quant c%0d", c), 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, (m == 3) || (m == 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
